// File: rtl/nios2_fmeasure_sqr_ctrl.sv
// Measurement-window sequencer for the AGC power path: squares and
// accumulates signed samples over a 2^len window and publishes the mean
// square for the fmeasure_sqr PIO, with a small Avalon-MM control slave.
module nios2_fmeasure_sqr_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int MAX_LOG2 = 12,
    parameter int ACC_W    = 44   // >= 2*SAMPLE_W-2+MAX_LOG2+1 and >= 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 address,
    input  logic                       write,
    input  logic [31:0]                writedata,
    input  logic                       read,
    output logic [31:0]                readdata,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic signed [SAMPLE_W-1:0] sample_data,
    output logic [31:0]                sqr_result,
    output logic                       irq
);
    localparam int CW = MAX_LOG2 + 1;
    localparam int PW = 2*SAMPLE_W - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic                run, irq_en, done;
    logic [3:0]          len, len_q;
    logic [MAX_LOG2-1:0] cnt;
    logic                drain_cnt;
    logic [PW-1:0]       p1_prod;
    logic                p1_vld;
    logic [ACC_W-1:0]    acc, acc_shr;
    logic signed [2*SAMPLE_W-1:0] sq;
    logic [CW-1:0]       win_last;
    logic                wr_ctrl, wr_len, wr_stat, run_nxt, abort, accept, last_beat, start;
    logic                unused_ok;

    assign wr_ctrl = write && (address == 2'd0);
    assign wr_len  = write && (address == 2'd1);
    assign wr_stat = write && (address == 2'd2);

    // A pending CTRL write takes effect immediately for abort/continue decisions,
    // so ready drops in the very cycle run is cleared.
    assign run_nxt = wr_ctrl ? writedata[0] : run;
    assign abort   = ((state == ACCUM) || (state == DRAIN)) && !run_nxt;

    assign sample_ready = (state == ACCUM) && !abort;
    assign accept       = sample_valid && sample_ready;

    assign win_last  = (CW'(1) << len_q) - CW'(1);
    assign last_beat = accept && ({1'b0, cnt} == win_last);
    assign start     = (state_nxt == ACCUM) && (state != ACCUM);

    // Square of a signed sample always fits in 2*SAMPLE_W-1 unsigned bits.
    assign sq      = sample_data * sample_data;
    assign acc_shr = acc >> len_q;

    assign unused_ok = ^{read, writedata[31:4], sq[2*SAMPLE_W-1], acc_shr};

    // Window sequencer next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (run) state_nxt = ACCUM;
            ACCUM: if (abort) state_nxt = IDLE;
                   else if (last_beat) state_nxt = DRAIN;
            DRAIN: if (abort) state_nxt = IDLE;
                   else if (drain_cnt) state_nxt = DONE;
            DONE:  state_nxt = run_nxt ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Square/accumulate pipeline, beat counter and drain timer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            p1_prod   <= '0;
            p1_vld    <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            if (start) begin
                acc    <= '0;
                cnt    <= '0;
                len_q  <= len;
                p1_vld <= 1'b0;
            end else begin
                p1_vld <= accept;
                if (accept) begin
                    p1_prod <= sq[PW-1:0];
                    cnt     <= cnt + 1'b1;
                end
                // In-flight product is dropped on abort
                if (p1_vld && !abort) acc <= acc + ACC_W'(p1_prod);
            end
            if (state == DRAIN) drain_cnt <= ~drain_cnt;
            else                drain_cnt <= 1'b0;
        end
    end

    // Control registers, sticky done, result latch and interrupt
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run        <= 1'b0;
            irq_en     <= 1'b0;
            len        <= '0;
            done       <= 1'b0;
            sqr_result <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_ctrl) {irq_en, run} <= writedata[1:0];
            if (wr_len)  len <= (writedata[3:0] > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : writedata[3:0];
            // Set in DONE wins over a simultaneous write-1-to-clear
            done <= (state == DONE) || (done && !(wr_stat && writedata[1]));
            if (state == DONE) sqr_result <= acc_shr[31:0];
            irq <= done && irq_en;
        end
    end

    // Registered read mux, updated every cycle regardless of the read strobe
    always_ff @(posedge clk) begin
        if (!reset_n) readdata <= '0;
        else begin
            case (address)
                2'd0:    readdata <= {30'b0, irq_en, run};
                2'd1:    readdata <= {28'b0, len};
                2'd2:    readdata <= {30'b0, done, state != IDLE};
                default: readdata <= sqr_result;
            endcase
        end
    end
endmodule

// File: tb/tb_nios2_fmeasure_sqr_ctrl.sv
// Bench for nios2_fmeasure_sqr_ctrl: directed and randomized windows checked
// against a mean-of-squares model over the beats the handshake accepted.
module tb_nios2_fmeasure_sqr_ctrl;
    localparam int SW = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [1:0]           address = '0;
    logic                 write = 1'b0;
    logic                 read = 1'b0;
    logic [31:0]          writedata = '0;
    logic [31:0]          readdata;
    logic                 sample_valid = 1'b0;
    logic                 sample_ready;
    logic signed [SW-1:0] sample_data = '0;
    logic [31:0]          sqr_result;
    logic                 irq;

    nios2_fmeasure_sqr_ctrl #(.SAMPLE_W(SW), .MAX_LOG2(12), .ACC_W(44)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data), .sqr_result(sqr_result), .irq(irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;
    logic [31:0] prev_res = '0;
    logic signed [SW-1:0] data_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && sample_ready !== 1'b1; i++) tick();
        chk("wait_ready", {31'b0, sample_ready}, 32'd1);
    endtask

    task automatic start(input int len, input logic [1:0] ctrl);
        wr(2'd0, 32'd0);
        wr(2'd1, len);
        wr(2'd0, {30'b0, ctrl});
        wait_ready();
    endtask

    task automatic fill(input int n, input int mode, input logic signed [SW-1:0] v);
        data_q.delete();
        for (int i = 0; i < n; i++)
            data_q.push_back(mode == 0 ? v : SW'($urandom));
    endtask

    // Feed one full window from data_q at the given valid duty; the model sums
    // squares of accepted beats and expects the mean 3 cycles after the last.
    task automatic feed(input int len, input int duty, input bit w1c_done);
        longint sum = 0;
        int n = 0;
        int budget = 0;
        int total = 1 << len;
        logic [31:0] exp;
        while (n < total && budget < 20000) begin
            sample_valid = ($urandom_range(99) < duty);
            sample_data = data_q[0];
            #1;
            if (sample_valid && sample_ready) begin
                sum += longint'(sample_data) * longint'(sample_data);
                void'(data_q.pop_front());
                n++;
            end
            tick();
            budget++;
        end
        chk("beats_accepted", n, total);
        exp = 32'(sum >> len);
        sample_valid = 1'b1;
        sample_data = SW'($urandom);
        chk("gap_ready_drain1", {31'b0, sample_ready}, 32'd0);
        tick();
        chk("gap_ready_drain2", {31'b0, sample_ready}, 32'd0);
        chk("result_early", sqr_result, prev_res);
        tick();
        chk("gap_ready_done", {31'b0, sample_ready}, 32'd0);
        chk("result_hold", sqr_result, prev_res);
        if (w1c_done) begin
            address = 2'd2; writedata = 32'd2; write = 1'b1;
        end
        tick();
        write = 1'b0;
        sample_valid = 1'b0;
        chk("result", sqr_result, exp);
        prev_res = exp;
    endtask

    initial begin
        logic [31:0] d;
        int cur_len, nxt_len, n;

        // Reset and readback
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_ready", {31'b0, sample_ready}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_result", sqr_result, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("rst_reg", d, 32'd0);
        end
        wr(2'd1, 32'd15);
        rd(2'd1, d);
        chk("len_clamp", d, 32'd12);

        // Single window 3,-4,5,0 -> 50>>2
        start(2, 2'b01);
        data_q = '{16'sd3, -16'sd4, 16'sd5, 16'sd0};
        feed(2, 100, 1'b0);
        chk("single_value", sqr_result, 32'd12);
        rd(2'd2, d);
        chk("single_status", d, 32'd3);

        // Boundary values
        start(0, 2'b01);
        fill(1, 0, -16'sd32768);
        feed(0, 100, 1'b0);
        chk("len0_max", sqr_result, 32'h4000_0000);
        start(12, 2'b01);
        fill(4096, 0, -16'sd32768);
        feed(12, 100, 1'b0);

        // Backpressure, 8 x 1000 at 50% valid
        start(3, 2'b01);
        fill(8, 0, 16'sd1000);
        feed(3, 50, 1'b0);
        chk("bp_value", sqr_result, 32'd1000000);

        // Continuous random windows, LEN rewritten mid-window
        cur_len = $urandom_range(0, 6);
        start(cur_len, 2'b01);
        for (int w = 0; w < 6; w++) begin
            nxt_len = $urandom_range(0, 6);
            wr(2'd1, nxt_len);
            fill(1 << cur_len, 1, 16'sd0);
            feed(cur_len, $urandom_range(30, 100), 1'b0);
            cur_len = nxt_len;
        end

        // Abort after 5 accepts
        start(4, 2'b01);
        wr(2'd2, 32'd2);
        n = 0;
        sample_valid = 1'b1;
        for (int b = 0; b < 50 && n < 5; b++) begin
            sample_data = SW'($urandom);
            #1;
            if (sample_ready) n++;
            tick();
        end
        chk("abort_beats", n, 5);
        wr(2'd0, 32'd0);
        chk("abort_ready", {31'b0, sample_ready}, 32'd0);
        sample_valid = 1'b0;
        rd(2'd2, d);
        chk("abort_status", d, 32'd0);
        chk("abort_result", sqr_result, prev_res);
        wr(2'd0, 32'd1);
        wait_ready();
        fill(16, 1, 16'sd0);
        feed(4, 70, 1'b0);

        // Interrupt and W1C
        start(1, 2'b11);
        wr(2'd2, 32'd2);
        fill(2, 1, 16'sd0);
        feed(1, 100, 1'b0);
        chk("irq_latency", {31'b0, irq}, 32'd0);
        tick();
        chk("irq_set", {31'b0, irq}, 32'd1);
        wr(2'd2, 32'd2);
        chk("irq_hold", {31'b0, irq}, 32'd1);
        tick();
        chk("irq_clr", {31'b0, irq}, 32'd0);
        fill(2, 1, 16'sd0);
        feed(1, 100, 1'b1);
        rd(2'd2, d);
        chk("w1c_in_done", d, 32'd3);
        chk("irq_after_w1c_done", {31'b0, irq}, 32'd1);

        // Reset mid-window
        start(2, 2'b01);
        sample_valid = 1'b1;
        sample_data = 16'sd77;
        tick(); tick();
        reset_n = 1'b0;
        sample_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        prev_res = '0;
        chk("mid_rst_result", sqr_result, 32'd0);
        chk("mid_rst_ready", {31'b0, sample_ready}, 32'd0);
        rd(2'd2, d);
        chk("mid_rst_status", d, 32'd0);
        rd(2'd0, d);
        chk("mid_rst_ctrl", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/nios2_fmeasure_sqr_ctrl.md
Name: nios2_fmeasure_sqr_ctrl

Overview:
Measurement-window sequencer for the AGC power path. It accepts a stream of signed audio samples, squares and accumulates them over a programmable power-of-two window, and publishes the mean square as a 32-bit word. That word drives the fmeasure_sqr PIO in_port, which the Nios II software reads. The Nios II configures, starts, aborts and polls the block through a small Avalon-MM slave; an optional interrupt signals window completion.

Parameters:
SAMPLE_W, 16, sample width (signed two's complement)
MAX_LOG2, 12, largest allowed log2 window length
ACC_W, 44, accumulator width; must be ≥ 2*SAMPLE_W-2+MAX_LOG2+1

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
address  input  2  Avalon register select
write  input  1  Avalon write strobe
writedata  input  32  Avalon write data
read  input  1  Avalon read strobe
readdata  output  32  Avalon read data, registered
sample_valid  input  1  sample handshake valid
sample_ready  output  1  sample handshake ready
sample_data  input  SAMPLE_W  signed audio sample
sqr_result  output  32  latched mean square, to PIO in_port
irq  output  1  level interrupt, done & irq_en

Behaviour:
- Reset: one clock with reset_n low, sampled at clk edge, forces:
  - outputs: readdata=0, sqr_result=0, irq=0, sample_ready=0;
  - internal: state=IDLE, all registers 0.
- Register map, addresses 0-3:
  - 0 CTRL, R/W: bit0 run, bit1 irq_en.
  - 1 LEN, R/W: bits[3:0] log2 window length. Writes > MAX_LOG2 are clamped to MAX_LOG2.
  - 2 STATUS: bit0 busy (RO, state≠IDLE); bit1 done (sticky, write-1-to-clear).
  - 3 RESULT, RO: copy of sqr_result.
- Reads: readdata is updated every clk (read strobe ignored) with the mux of address, giving 1-cycle latency. Unused bits read 0.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE: if run=1, go to ACCUM. On entry to ACCUM: acc=0, cnt=0, LEN snapshot taken as len_q.
  - ACCUM: sample_ready=1. A beat is accepted when valid&ready. On acceptance, cnt increments.
    - When cnt reaches (1<<len_q)-1 and that beat is accepted, go to DRAIN.
  - DRAIN: sample_ready=0 for exactly 2 cycles, which flushes the square and add pipeline stages. Then go to DONE.
  - DONE, lasting 1 cycle:
    - sqr_result = acc >> len_q, low 32 bits. This never exceeds 2^30, so no saturation is needed.
    - done sets to 1.
    - If run=1, go to ACCUM (fresh acc, cnt and len_q); otherwise go to IDLE.
- Datapath pipeline:
  - stage 1 registers sample_data*sample_data as unsigned 2*SAMPLE_W-1 bits;
  - stage 2 adds the product into acc.
  - Only accepted beats enter the pipeline.
- Abort: writing run=0 while in ACCUM or DRAIN:
  - goes to IDLE on the next cycle;
  - sample_ready drops that cycle;
  - sqr_result and done are unchanged;
  - pipeline contents are discarded.
- Writing run=1 while already running has no effect. LEN writes mid-window affect only the next window.
- Simultaneous events: when done-set (DONE state) and a W1C to done occur in the same cycle, set wins.
- irq = done & irq_en, registered, so it has 1-cycle latency from either term.
- Window length 1 (len_q=0): go to DRAIN after the first accepted beat; result equals that sample's square.
- Throughput is 1 sample/cycle in ACCUM. In continuous mode there is a 3-cycle ready gap between windows (2 DRAIN cycles + 1 DONE cycle).
- Reset asserted mid-window: everything returns to reset values; no partial result is published.

Test Plan:
- Reset/readback: after reset, read addresses 0-3 → all 0 and irq=0. Write LEN=15 and read it back → 12.
- Single window: LEN=2, CTRL=1, then feed samples 3, -4, 5, 0 with valid held high.
  - done=1 and sqr_result=12 (50>>2) exactly 3 cycles after the 4th accept.
  - The FSM stays in ACCUM because run=1.
- Boundary value: LEN=0, feed -32768 → sqr_result=0x40000000. Also LEN=12 with all samples -32768 → 0x40000000, with no overflow.
- Backpressure: LEN=3, drive valid with a random 50% duty cycle, 8 samples of 1000 → result 1000000. Check that no beat is accepted in DRAIN/DONE.
- Abort: LEN=4, start, after 5 accepts write CTRL=0.
  - sample_ready falls next cycle; busy=0; sqr_result holds its prior value; done unchanged.
- IRQ/W1C: irq_en=1 with a window completing gives irq=1. Write STATUS bit1=1 → irq=0 next cycle. A W1C issued in the DONE cycle leaves done=1.
